// File: rtl/hyperram_burst_ctrl.sv
// HyperBus burst master: CA / latency / transfer sequencing, register space,
// byte-masked writes, read capture pipeline and device reset hold.
module hyperram_burst_ctrl #(
  parameter int ADDR_W        = 22,
  parameter int LATENCY       = 6,
  parameter int FIXED_LATENCY = 1,
  parameter int BURST_MAX     = 32,
  parameter int RD_CAP_DLY    = 2,
  parameter int CS_GAP        = 2,
  parameter int RST_HOLD      = 16,
  localparam int LW = $clog2(BURST_MAX) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic              cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LW-1:0]     cmd_len,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_mask,
  output logic              wr_ready,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              hr_ck_en,
  output logic              hr_cs_n,
  output logic              hr_rst_n,
  output logic              hr_dq_oe,
  output logic              hr_rwds_oe,
  output logic [7:0]        hr_dq_o0,
  output logic [7:0]        hr_dq_o1,
  output logic              hr_rwds_o0,
  output logic              hr_rwds_o1,
  input  logic [7:0]        hr_dq_i0,
  input  logic [7:0]        hr_dq_i1,
  input  logic              hr_rwds_i0
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_CA, S_LAT, S_XFER, S_FIN, S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              reg_q, reg_d;
  logic              lat2_q, lat2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     len_clamp;
  logic [CW-1:0]     lat_len;

  logic        cs_n_q, cs_n_d;
  logic        ck_en_q, ck_en_d;
  logic        rst_n_q, rst_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        rwds_oe_q, rwds_oe_d;
  logic [7:0]  dq0_q, dq0_d;
  logic [7:0]  dq1_q, dq1_d;
  logic        rw0_q, rw0_d;
  logic        rw1_q, rw1_d;
  logic        wr_ready_c;
  logic [47:0] ca;

  logic                  samp;
  logic [RD_CAP_DLY-1:0] pv_q, pv_d;
  logic [15:0]           pd_q [RD_CAP_DLY];
  logic [15:0]           pd_d [RD_CAP_DLY];

  assign lat_len = lat2_q ? CW'(2 * LATENCY) : CW'(LATENCY);

  // Clamp requested burst length into 1..BURST_MAX
  always_comb begin
    len_clamp = cmd_len;
    if (cmd_len == '0)
      len_clamp = LW'(1);
    else if (cmd_len > LW'(BURST_MAX))
      len_clamp = LW'(BURST_MAX);
  end

  // Next-state, phase counter and command latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    rd_d    = rd_q;
    reg_d   = reg_q;
    addr_d  = addr_q;
    len_d   = len_q;
    lat2_d  = lat2_q;
    unique case (state_q)
      S_RST: begin
        if (cnt_q == CW'(RST_HOLD)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d = S_CA;
          rd_d    = cmd_rd;
          reg_d   = cmd_reg;
          addr_d  = cmd_addr;
          len_d   = (cmd_reg && !cmd_rd) ? LW'(1) : len_clamp;
        end
      end
      S_CA: begin
        if (cnt_q == '0)
          lat2_d = (FIXED_LATENCY != 0) || hr_rwds_i0;
        if (cnt_q == CW'(2)) begin
          cnt_d   = '0;
          state_d = (reg_q && !rd_q) ? S_XFER : S_LAT;
        end
      end
      S_LAT: begin
        if (cnt_q == lat_len - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (cnt_q == CW'(len_q) - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CW'(CS_GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_RST;
      end
    endcase
  end

  // Pad values for the coming cycle, decoded from the next state
  always_comb begin
    cs_n_d     = 1'b1;
    ck_en_d    = 1'b0;
    rst_n_d    = 1'b1;
    dq_oe_d    = 1'b0;
    rwds_oe_d  = 1'b0;
    dq0_d      = '0;
    dq1_d      = '0;
    rw0_d      = 1'b0;
    rw1_d      = 1'b0;
    wr_ready_c = 1'b0;
    ca = {rd_d, reg_d, 1'b1, 29'(addr_d[ADDR_W-1:3]),
          13'd0, addr_d[2:0]};
    unique case (state_d)
      S_RST: rst_n_d = (cnt_d >= CW'(RST_HOLD));
      S_CA: begin
        cs_n_d  = 1'b0;
        ck_en_d = 1'b1;
        dq_oe_d = 1'b1;
        unique case (cnt_d[1:0])
          2'd0:    {dq0_d, dq1_d} = ca[47:32];
          2'd1:    {dq0_d, dq1_d} = ca[31:16];
          default: {dq0_d, dq1_d} = ca[15:0];
        endcase
      end
      S_LAT: begin
        cs_n_d    = 1'b0;
        ck_en_d   = 1'b1;
        dq_oe_d   = !rd_d;
        rwds_oe_d = !rd_d;
      end
      S_XFER: begin
        cs_n_d  = 1'b0;
        ck_en_d = 1'b1;
        if (!rd_d) begin
          wr_ready_c     = 1'b1;
          dq_oe_d        = 1'b1;
          rwds_oe_d      = !reg_d;
          {dq0_d, dq1_d} = wr_data;
          rw0_d          = ~wr_mask[1];
          rw1_d          = ~wr_mask[0];
        end
      end
      S_FIN:   cs_n_d = 1'b0;
      default: ;
    endcase
  end

  // Read capture pipeline input and shift
  always_comb begin
    samp     = (state_q == S_XFER) && rd_q;
    pv_d[0]  = samp;
    pd_d[0]  = samp ? {hr_dq_i0, hr_dq_i1} : 16'h0;
    for (int i = 1; i < RD_CAP_DLY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  // State register and command latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      reg_q   <= 1'b0;
      lat2_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      reg_q   <= reg_d;
      lat2_q  <= lat2_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  // Registered pad outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_q    <= 1'b1;
      ck_en_q   <= 1'b0;
      rst_n_q   <= 1'b0;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      dq0_q     <= '0;
      dq1_q     <= '0;
      rw0_q     <= 1'b0;
      rw1_q     <= 1'b0;
    end else begin
      cs_n_q    <= cs_n_d;
      ck_en_q   <= ck_en_d;
      rst_n_q   <= rst_n_d;
      dq_oe_q   <= dq_oe_d;
      rwds_oe_q <= rwds_oe_d;
      dq0_q     <= dq0_d;
      dq1_q     <= dq1_d;
      rw0_q     <= rw0_d;
      rw1_q     <= rw1_d;
    end
  end

  // Read pipeline registers, flushed by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      for (int i = 0; i < RD_CAP_DLY; i++)
        pd_q[i] <= '0;
    end else begin
      pv_q <= pv_d;
      for (int i = 0; i < RD_CAP_DLY; i++)
        pd_q[i] <= pd_d[i];
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_RST);
  assign wr_ready   = wr_ready_c & ~reset;
  assign rd_valid   = pv_q[RD_CAP_DLY-1];
  assign rd_data    = pd_q[RD_CAP_DLY-1];
  assign hr_cs_n    = cs_n_q;
  assign hr_ck_en   = ck_en_q;
  assign hr_rst_n   = rst_n_q;
  assign hr_dq_oe   = dq_oe_q;
  assign hr_rwds_oe = rwds_oe_q;
  assign hr_dq_o0   = dq0_q;
  assign hr_dq_o1   = dq1_q;
  assign hr_rwds_o0 = rw0_q;
  assign hr_rwds_o1 = rw1_q;

endmodule

// File: tb/tb_hyperram_burst_ctrl.sv
// Directed bench for hyperram_burst_ctrl: reset hold, CA/latency timing,
// read capture, masked and register writes, length clamp, mid-burst reset.
module tb_hyperram_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_valid_b = 1'b0;
  logic        cmd_rd = 1'b0, cmd_reg = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [5:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic [7:0]  dq_i0 = '0, dq_i1 = '0;
  logic        rwds_i0 = 1'b0;

  logic        cmd_ready, wr_ready, rd_valid, busy;
  logic [15:0] rd_data;
  logic        ck_en, cs_n, rst_n, dq_oe, rwds_oe, rwds_o0, rwds_o1;
  logic [7:0]  dq_o0, dq_o1;

  logic        cmd_ready_b, wr_ready_b, rd_valid_b, busy_b;
  logic [15:0] rd_data_b;
  logic        ck_en_b, cs_n_b, rst_n_b, dq_oe_b, rwds_oe_b;
  logic        rwds_o0_b, rwds_o1_b;
  logic [7:0]  dq_o0_b, dq_o1_b;

  int checks = 0;
  int failures = 0;

  logic [15:0] rwords [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] wd     [3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
  logic [1:0]  wm     [3] = '{2'b11, 2'b10, 2'b01};
  logic [1:0]  wexp   [3] = '{2'b00, 2'b01, 2'b10};

  always #5 clk = ~clk;

  hyperram_burst_ctrl #(.FIXED_LATENCY(1)) u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_reg(cmd_reg),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .hr_ck_en(ck_en), .hr_cs_n(cs_n), .hr_rst_n(rst_n),
    .hr_dq_oe(dq_oe), .hr_rwds_oe(rwds_oe),
    .hr_dq_o0(dq_o0), .hr_dq_o1(dq_o1),
    .hr_rwds_o0(rwds_o0), .hr_rwds_o1(rwds_o1),
    .hr_dq_i0(dq_i0), .hr_dq_i1(dq_i1), .hr_rwds_i0(rwds_i0)
  );

  hyperram_burst_ctrl #(.FIXED_LATENCY(0)) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_rd(cmd_rd), .cmd_reg(cmd_reg),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_ready(wr_ready_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b),
    .hr_ck_en(ck_en_b), .hr_cs_n(cs_n_b), .hr_rst_n(rst_n_b),
    .hr_dq_oe(dq_oe_b), .hr_rwds_oe(rwds_oe_b),
    .hr_dq_o0(dq_o0_b), .hr_dq_o1(dq_o1_b),
    .hr_rwds_o0(rwds_o0_b), .hr_rwds_o1(rwds_o1_b),
    .hr_dq_i0(dq_i0), .hr_dq_i1(dq_i1), .hr_rwds_i0(rwds_i0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_seq();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ctl", {cs_n, rst_n, ck_en, dq_oe, rwds_oe,
                    cmd_ready, wr_ready, rd_valid, busy}, 9'b100000000);
    chk("rst_dat", {dq_o0, dq_o1, rwds_o0, rwds_o1, rd_data}, 0);
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("hold_rst_n", rst_n, c >= 16);
      chk("hold_ready", cmd_ready, c >= 17);
      chk("hold_cs_n", cs_n, 1);
      chk("hold_rdv", rd_valid, 0);
    end
  endtask

  initial begin
    int nrd, widx, nrdy, nfall, hirun, gap, n1, n2;
    logic pend, rwoe, prev, drop;
    logic [15:0] model;

    rst_seq();

    // fixed-latency read, 4 words
    cmd_valid = 1; cmd_rd = 1; cmd_reg = 0;
    cmd_addr = 22'h00012B; cmd_len = 6'd4; rwds_i0 = 0;
    {dq_i0, dq_i1} = 16'hEEEE;
    chk("rd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("rd_ca0", {cs_n, ck_en, dq_oe, dq_o0, dq_o1}, {3'b011, 16'hA000});
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_ca1", {dq_o0, dq_o1}, 16'h0025);
    tick();
    chk("rd_ca2", {dq_o0, dq_o1}, 16'h0003);
    nrd = 0;
    for (int rel = 3; rel <= 30; rel++) begin
      tick();
      model = 16'hEEEE;
      if (rel >= 15 && rel <= 18) model = rwords[rel-15];
      {dq_i0, dq_i1} = model;
      chk("rd_cs_n", cs_n, rel >= 20);
      if (rel <= 14) chk("rd_lat_oe", {dq_oe, rwds_oe}, 0);
      if (rd_valid) begin
        chk("rd_when", rel, 17 + nrd);
        chk("rd_data", rd_data, (nrd < 4) ? rwords[nrd & 3] : 16'hDEAD);
        nrd++;
      end
    end
    chk("rd_count", nrd, 4);

    // variable-latency masked write on second instance
    cmd_valid_b = 1; cmd_rd = 0; cmd_reg = 0;
    cmd_addr = 22'h000040; cmd_len = 6'd3; rwds_i0 = 0;
    wr_data = wd[0]; wr_mask = wm[0];
    tick();
    cmd_valid_b = 0;
    chk("wr_ca0", {dq_o0_b, dq_o1_b}, 16'h2000);
    widx = 0; pend = 0;
    for (int rel = 0; rel <= 25; rel++) begin
      if (pend) begin
        chk("wr_pad", {dq_o0_b, dq_o1_b}, wd[(widx-1) % 3]);
        chk("wr_rwds", {rwds_o0_b, rwds_o1_b}, wexp[(widx-1) % 3]);
        chk("wr_rwds_oe", rwds_oe_b, 1);
        pend = 0;
      end
      if (rel == 3)
        chk("wr_lat", {rwds_oe_b, rwds_o0_b, rwds_o1_b, dq_oe_b}, 4'b1001);
      if (widx < 3) begin
        wr_data = wd[widx];
        wr_mask = wm[widx];
      end
      if (wr_ready_b) begin
        chk("wr_when", rel, 8 + widx);
        widx++;
        pend = 1;
      end
      tick();
    end
    chk("wr_count", widx, 3);

    // register write: no latency, single word, no RWDS drive
    cmd_valid = 1; cmd_rd = 0; cmd_reg = 1;
    cmd_addr = 22'h000800; cmd_len = 6'd5;
    wr_data = 16'h8FEC; wr_mask = 2'b11;
    tick();
    cmd_valid = 0;
    chk("rg_ca0", {dq_o0, dq_o1}, 16'h6000);
    nrdy = 0; pend = 0; rwoe = 0;
    for (int rel = 0; rel <= 12; rel++) begin
      if (rel == 1) chk("rg_ca1", {dq_o0, dq_o1}, 16'h0100);
      if (pend) begin
        chk("rg_pad", {dq_o0, dq_o1}, 16'h8FEC);
        pend = 0;
      end
      rwoe = rwoe | rwds_oe;
      if (wr_ready) begin
        chk("rg_when", rel, 2);
        nrdy++;
        pend = 1;
      end
      tick();
    end
    chk("rg_rdy_cnt", nrdy, 1);
    chk("rg_rwds_oe", rwoe, 0);

    // back-to-back reads: len 0 then len 40
    cmd_valid = 1; cmd_rd = 1; cmd_reg = 0;
    cmd_addr = 22'h000010; cmd_len = 6'd0;
    {dq_i0, dq_i1} = 16'h5A5A;
    tick();
    cmd_len = 6'd40;
    nfall = 1; prev = 0; hirun = 0; gap = 0; n1 = 0; n2 = 0; drop = 0;
    for (int i = 0; i < 150; i++) begin
      if (!cs_n && prev) begin
        nfall++;
        gap = hirun;
      end
      hirun = cs_n ? hirun + 1 : 0;
      prev = cs_n;
      if (rd_valid) begin
        if (nfall == 1) n1++;
        else n2++;
      end
      if (cmd_valid && cmd_ready) drop = 1;
      tick();
      if (drop) begin
        cmd_valid = 0;
        drop = 0;
      end
    end
    chk("len0_words", n1, 1);
    chk("len40_words", n2, 32);
    chk("b2b_txns", nfall, 2);
    chk("b2b_gap", gap >= 2, 1);

    // reset during word 2 of an 8-word read
    cmd_valid = 1; cmd_rd = 1; cmd_reg = 0;
    cmd_addr = 22'h000000; cmd_len = 6'd8;
    tick();
    cmd_valid = 0;
    for (int rel = 1; rel <= 17; rel++) tick();
    chk("mid_cs_low", cs_n, 0);
    reset = 1;
    tick();
    chk("mid_rst", {cs_n, ck_en, dq_oe, rwds_oe, rd_valid}, 5'b10000);
    rst_seq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
